// File: rtl/pool_stream.sv
// pool_stream: streaming 2x2 stride-2 max-pool over all channels in parallel.
//
// Input pixels arrive one per beat in raster order, with every channel packed
// into a single beat. A horizontal pair is reduced in h_q. On even rows the pair
// maximum is parked in a half-row line buffer. On odd rows it is combined with
// the parked value to form one pooled pixel.
//
// Optional build macro: POOL_SIGNED_EN
//   defined   -> channel values are two's-complement and the max is signed
//   undefined -> unsigned max (for DATA_W=1 this is a plain OR)
//
// Handshake (both ports use strict valid/ready):
//   A beat moves on a port only in a cycle where valid && ready is high at the
//   rising clock edge. A producer holds valid, and the payload that goes with
//   it, stable until that edge. in_ready = !out_valid || out_ready. It depends
//   only on the output stage, never on in_valid. Every beat is gated the same
//   way, so an output stage that is stalled also stalls the input.

module pool_stream #(
    parameter int CHANNELS = 20,
    parameter int DATA_W   = 1,
    parameter int IMG_W    = 24,
    parameter int IMG_H    = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sof,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    output logic                         out_eof
);

    localparam int PIX_W = CHANNELS * DATA_W;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LB_N  = IMG_W / 2;
    localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

    // Channel-wise maximum of two packed pixels.
    function automatic logic [PIX_W-1:0] pix_max(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
        logic [PIX_W-1:0]  res;
        logic [DATA_W-1:0] av;
        logic [DATA_W-1:0] bv;
        res = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            av = a[c*DATA_W +: DATA_W];
            bv = b[c*DATA_W +: DATA_W];
`ifdef POOL_SIGNED_EN
            res[c*DATA_W +: DATA_W] = ($signed(av) > $signed(bv)) ? av : bv;
`else
            res[c*DATA_W +: DATA_W] = (av > bv) ? av : bv;
`endif
        end
        return res;
    endfunction

    // Position counters and the horizontal partial maximum.
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [PIX_W-1:0] h_q, h_d;

    // Registered output stage.
    logic             out_valid_q, out_valid_d;
    logic [PIX_W-1:0] out_data_q, out_data_d;
    logic             out_eof_q, out_eof_d;

    // Half-row line buffer. Within a frame every entry is written on an even
    // row before it is read on the following odd row, so it needs no reset.
    logic [PIX_W-1:0] lbuf_q [LB_N];
    logic             lb_we;
    logic [LB_AW-1:0] lb_idx;
    logic [PIX_W-1:0] lb_wdata;

    // Datapath helpers.
    logic             accept;
    logic [COL_W-1:0] col_eff;
    logic [ROW_W-1:0] row_eff;
    logic             col_last;
    logic             row_last;
    logic [PIX_W-1:0] hmax;
    logic [PIX_W-1:0] vmax;

    assign in_ready  = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_eof   = out_eof_q;

    // Next-state logic: counters, horizontal/vertical reduction and output stage.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        h_d         = h_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_eof_d   = out_eof_q;
        lb_we       = 1'b0;

        accept   = in_valid && in_ready;

        // A start-of-frame beat forces position (0,0). Any partial window of
        // the previous frame is abandoned. Its even-row entries are later
        // overwritten before they are read, and h_q is overwritten on every
        // even column.
        col_eff  = in_sof ? '0 : col_q;
        row_eff  = in_sof ? '0 : row_q;
        col_last = (col_eff == COL_W'(IMG_W - 1));
        row_last = (row_eff == ROW_W'(IMG_H - 1));

        lb_idx   = LB_AW'(col_eff >> 1);
        hmax     = pix_max(h_q, in_data);
        vmax     = pix_max(lbuf_q[lb_idx], hmax);
        lb_wdata = hmax;

        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_eff + ROW_W'(1);
            end else begin
                col_d = col_eff + COL_W'(1);
                row_d = row_eff;
            end

            if (!col_eff[0]) begin
                h_d = in_data;
            end else if (!row_eff[0]) begin
                lb_we = 1'b1;
            end else begin
                // The bottom-right pixel of a window completes it. A new
                // result overrides a transfer in the same cycle, so out_valid
                // stays high.
                out_valid_d = 1'b1;
                out_data_d  = vmax;
                out_eof_d   = row_last && col_last;
            end
        end
    end

    // State registers with asynchronous reset. Reset drops any pending output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            h_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_eof_q   <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            h_q         <= h_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_eof_q   <= out_eof_d;
        end
    end

    // Line buffer write port. This storage has no reset.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lbuf_q[lb_idx] <= lb_wdata;
        end
    end

endmodule

// File: tb/tb_pool_stream.sv
// Testbench for pool_stream. Two instances are used:
//   u_dut_a: default parameters (20 channels x 1 bit, 24x24 frame), with random back-pressure
//   u_dut_b: 2 channels x 8 bit, 4x4 frame, for the value, stall, sof and reset cases
// Expected pooled pixels come from a window model over the bench's own frame
// data. They are queued when the bottom-right beat of a window is driven.

module tb_pool_stream;

    localparam int A_CH = 20;
    localparam int A_W  = 24;
    localparam int A_H  = 24;
    localparam int B_W  = 4;
    localparam int B_H  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;

    logic        in_valid_a, in_ready_a, in_sof_a, out_valid_a, out_ready_a, out_eof_a;
    logic [19:0] in_data_a, out_data_a;
    logic        in_valid_b, in_ready_b, in_sof_b, out_valid_b, out_ready_b, out_eof_b;
    logic [15:0] in_data_b, out_data_b;

    pool_stream u_dut_a (
        .clk(clk), .rst(rst_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_sof(in_sof_a), .in_data(in_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a), .out_eof(out_eof_a)
    );

    pool_stream #(.CHANNELS(2), .DATA_W(8), .IMG_W(B_W), .IMG_H(B_H)) u_dut_b (
        .clk(clk), .rst(rst_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_sof(in_sof_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .out_eof(out_eof_b)
    );

    // ---------------- checking ----------------
    int total_cnt = 0;
    int bad_cnt   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [20:0] exp_q_a[$];   // {eof, data}
    logic [16:0] exp_q_b[$];   // {eof, data}
    logic [15:0] fb [B_H][B_W];

    function automatic logic mx1(input logic a, input logic b);
`ifdef POOL_SIGNED_EN
        return a & b;          // 1-bit two's complement: 1 is -1, so the max is 0 unless both are 1
`else
        return a | b;
`endif
    endfunction

    function automatic logic [7:0] mx8(input logic [7:0] a, input logic [7:0] b);
`ifdef POOL_SIGNED_EN
        return ($signed(a) >= $signed(b)) ? a : b;
`else
        return (a >= b) ? a : b;
`endif
    endfunction

    function automatic logic [19:0] pix_a(input int r, input int x);
        logic [19:0] v;
        v = '0;
        for (int c = 0; c < A_CH; c++)
            if (r == (2 * c) % 24 && x == (2 * c + 1) % 24) v[c] = 1'b1;
        return v;
    endfunction

    // r,x is the bottom-right pixel of the window.
    function automatic logic [19:0] exp_a(input int r, input int x);
        logic [19:0] p00, p01, p10, p11, v;
        p00 = pix_a(r - 1, x - 1); p01 = pix_a(r - 1, x);
        p10 = pix_a(r, x - 1);     p11 = pix_a(r, x);
        for (int c = 0; c < A_CH; c++)
            v[c] = mx1(mx1(p00[c], p01[c]), mx1(p10[c], p11[c]));
        return v;
    endfunction

    function automatic logic [15:0] exp_b(input int r, input int x);
        logic [15:0] p00, p01, p10, p11, v;
        p00 = fb[r-1][x-1]; p01 = fb[r-1][x];
        p10 = fb[r][x-1];   p11 = fb[r][x];
        for (int c = 0; c < 2; c++)
            v[c*8 +: 8] = mx8(mx8(p00[c*8 +: 8], p01[c*8 +: 8]), mx8(p10[c*8 +: 8], p11[c*8 +: 8]));
        return v;
    endfunction

    // ---------------- scoreboard monitors ----------------
    always begin
        @(negedge clk); #2;
        if (!rst_a && out_valid_a && out_ready_a) begin
            if (exp_q_a.size() == 0) check_eq("a_unexpected_out", 32'(exp_q_a.size()), 1);
            else check_eq("a_out", 32'({out_eof_a, out_data_a}), 32'(exp_q_a.pop_front()));
        end
    end

    always begin
        @(negedge clk); #2;
        if (!rst_b && out_valid_b && out_ready_b) begin
            if (exp_q_b.size() == 0) check_eq("b_unexpected_out", 32'(exp_q_b.size()), 1);
            else check_eq("b_out", 32'({out_eof_b, out_data_b}), 32'(exp_q_b.pop_front()));
        end
    end

    // ---------------- drivers ----------------
    task automatic send_a(input int r, input int x, input bit sof);
        int  waitc;
        bit  br;
        br = (r % 2 == 1) && (x % 2 == 1);
        @(negedge clk);
        out_ready_a = ($urandom_range(0, 3) != 0);
        in_valid_a  = 1'b1;
        in_sof_a    = sof;
        in_data_a   = pix_a(r, x);
        if (br) exp_q_a.push_back({(r == A_H - 1) && (x == A_W - 1), exp_a(r, x)});
        #1;
        waitc = 0;
        while (!in_ready_a && waitc < 100) begin
            @(negedge clk);
            out_ready_a = ($urandom_range(0, 3) != 0);
            #1;
            waitc++;
        end
        if (!in_ready_a) check_eq("a_ready_timeout", 32'(in_ready_a), 1);
        @(posedge clk); #1;
        if (br) check_eq("a_latency", 32'(out_valid_a), 1);
        in_valid_a = 1'b0;
        in_sof_a   = 1'b0;
    endtask

    task automatic send_b(input int r, input int x, input bit sof);
        int  waitc;
        bit  br;
        br = (r % 2 == 1) && (x % 2 == 1);
        @(negedge clk);
        in_valid_b = 1'b1;
        in_sof_b   = sof;
        in_data_b  = fb[r][x];
        if (br) exp_q_b.push_back({(r == B_H - 1) && (x == B_W - 1), exp_b(r, x)});
        #1;
        waitc = 0;
        while (!in_ready_b && waitc < 100) begin
            @(negedge clk); #1;
            waitc++;
        end
        if (!in_ready_b) check_eq("b_ready_timeout", 32'(in_ready_b), 1);
        @(posedge clk); #1;
        if (br) check_eq("b_latency", 32'(out_valid_b), 1);
        in_valid_b = 1'b0;
        in_sof_b   = 1'b0;
    endtask

    // Hold out_ready low for 5 cycles while offering pixel (r,x); it must not be taken.
    task automatic stall_b(input int r, input int x);
        logic [16:0] held;
        held = exp_q_b[$];
        @(negedge clk);
        out_ready_b = 1'b0;
        in_valid_b  = 1'b1;
        in_sof_b    = 1'b0;
        in_data_b   = fb[r][x];
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check_eq("stall_in_ready", 32'(in_ready_b), 0);
            check_eq("stall_out_valid", 32'(out_valid_b), 1);
            check_eq("stall_held", 32'({out_eof_b, out_data_b}), 32'(held));
        end
        @(negedge clk);
        out_ready_b = 1'b1;
        in_valid_b  = 1'b0;
    endtask

    task automatic send_frame_b(input bit first_sof, input bit with_stall);
        for (int r = 0; r < B_H; r++)
            for (int x = 0; x < B_W; x++) begin
                send_b(r, x, first_sof && r == 0 && x == 0);
                if (with_stall && r == 1 && x == 1) stall_b(1, 2);
            end
    endtask

    task automatic fill_random_b();
        for (int r = 0; r < B_H; r++)
            for (int x = 0; x < B_W; x++) fb[r][x] = 16'($urandom);
    endtask

    task automatic drain_b(input string tag);
        int waitc;
        waitc = 0;
        while (exp_q_b.size() != 0 && waitc < 50) begin @(negedge clk); waitc++; end
        @(negedge clk); @(negedge clk);
        check_eq(tag, 32'(exp_q_b.size()), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int waitc;
        rst_a = 1'b1; rst_b = 1'b1;
        in_valid_a = 1'b0; in_sof_a = 1'b0; in_data_a = '0; out_ready_a = 1'b1;
        in_valid_b = 1'b0; in_sof_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk); #1;
        check_eq("rst_a_out_valid", 32'(out_valid_a), 0);
        check_eq("rst_a_out_data", 32'(out_data_a), 0);
        check_eq("rst_a_out_eof", 32'(out_eof_a), 0);
        check_eq("rst_a_in_ready", 32'(in_ready_a), 1);
        check_eq("rst_b_out_valid", 32'(out_valid_b), 0);
        check_eq("rst_b_out_data", 32'(out_data_b), 0);
        check_eq("rst_b_out_eof", 32'(out_eof_b), 0);
        check_eq("rst_b_in_ready", 32'(in_ready_b), 1);

        // Ramp frame r*4+x on both channels (outputs 5,7,13,15) with a stall.
        for (int r = 0; r < B_H; r++)
            for (int x = 0; x < B_W; x++) fb[r][x] = {8'(r * 4 + x), 8'(r * 4 + x)};
        send_frame_b(1'b1, 1'b1);
        drain_b("b_drain_ramp");

        // Random frame back-to-back, sof on (0,0) is a no-op.
        fill_random_b();
        send_frame_b(1'b1, 1'b0);
        drain_b("b_drain_rand");

        // Signed/unsigned window on channel 0.
        fill_random_b();
        fb[0][0][7:0] = 8'h80; fb[0][1][7:0] = 8'hFF;
        fb[1][0][7:0] = 8'h01; fb[1][1][7:0] = 8'h7F;
        send_frame_b(1'b0, 1'b0);
        drain_b("b_drain_sign");

        // Mid-frame sof at position (1,3): window (0,1) is abandoned.
        fill_random_b();
        for (int x = 0; x < B_W; x++) send_b(0, x, 1'b0);
        for (int x = 0; x < 3; x++) send_b(1, x, 1'b0);
        fill_random_b();
        send_frame_b(1'b1, 1'b0);
        drain_b("b_drain_sof");

        // Asynchronous reset between edges with an output pending.
        fill_random_b();
        for (int x = 0; x < B_W; x++) send_b(0, x, 1'b0);
        send_b(1, 0, 1'b0);
        send_b(1, 1, 1'b0);
        #1;
        rst_b = 1'b1;
        #1;
        check_eq("arst_out_valid", 32'(out_valid_b), 0);
        check_eq("arst_out_data", 32'(out_data_b), 0);
        check_eq("arst_out_eof", 32'(out_eof_b), 0);
        check_eq("arst_in_ready", 32'(in_ready_b), 1);
        exp_q_b.delete();
        @(negedge clk);
        rst_b = 1'b0;
        fill_random_b();
        send_frame_b(1'b0, 1'b0);
        drain_b("b_drain_rst");

        // Default-parameter 24x24 binary frame with random back-pressure.
        for (int r = 0; r < A_H; r++)
            for (int x = 0; x < A_W; x++) send_a(r, x, r == 0 && x == 0);
        @(negedge clk);
        out_ready_a = 1'b1;
        waitc = 0;
        while (exp_q_a.size() != 0 && waitc < 50) begin @(negedge clk); waitc++; end
        @(negedge clk); @(negedge clk);
        check_eq("a_drain", 32'(exp_q_a.size()), 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/pool_stream.md
Name: pool_stream

Overview:
- Streaming, parametrised 2x2 stride-2 max-pool for all channels of a feature map at once.
- Successor to the per-layer combinational pooling blocks: accepts one pixel per beat in raster order, all channels in parallel.
- Holds one half-row of partial maxima in a line buffer and emits one pooled pixel per 2x2 window over a valid/ready stream.
- Sits between a conv layer's output stream and the next layer's input. With DATA_W=1 (binary maps) the max reduces to OR.

Parameters:
- CHANNELS, 20, feature maps processed in parallel.
- DATA_W, 1, bits per channel value.
- IMG_W, 24, input columns; must be even and >= 2.
- IMG_H, 24, input rows; must be even and >= 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_sof  input  1  beat is pixel (0,0) of a frame.
- in_data  input  CHANNELS*DATA_W  channel c at bits [c*DATA_W +: DATA_W].
- out_valid  output  1  pooled pixel valid.
- out_ready  input  1  downstream accepts.
- out_data  output  CHANNELS*DATA_W  pooled pixel, same packing as in_data.
- out_eof  output  1  qualifies the last pooled pixel of a frame, at (IMG_H/2-1, IMG_W/2-1).

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_eof=0, in_ready=1.
  - col=0, row=0, h_reg=0.
  - Line buffer is not reset; it is always written before it is read within a frame.
- Accept and output handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = !out_valid || out_ready, applied uniformly to every beat.
  - An output is held stable while out_valid && !out_ready.
  - Transfer occurs when out_valid && out_ready. If no new output is produced in the same cycle, out_valid clears next cycle.
- Counters:
  - col counts 0..IMG_W-1 and row counts 0..IMG_H-1, advancing on each accept.
  - col wraps to 0 and row increments at IMG_W-1.
  - row wraps to 0 at IMG_H-1 and col=IMG_W-1.
- Per accepted beat, with channel-wise unsigned max:
  - Even col: h_reg <= in_data.
  - Odd col: hmax = max(h_reg, in_data).
  - Even row, odd col: lbuf[col>>1] <= hmax.
  - Odd row, odd col: out_data <= max(lbuf[col>>1], hmax), out_valid <= 1, out_eof <= (row==IMG_H-1 && col==IMG_W-1).
- Latency and rate:
  - Output is registered one cycle after accepting the bottom-right pixel of a window.
  - Outputs per frame = (IMG_W/2)*(IMG_H/2).
  - Full throughput (1 beat/cycle) when out_ready is held high.
- Line buffer: IMG_W/2 entries of CHANNELS*DATA_W bits, index width clog2(IMG_W/2) with a minimum of 1.
- Frame resynchronisation:
  - An accepted beat with in_sof=1 is treated as (0,0) regardless of the counter state.
  - Partial windows are discarded; no output is produced for them.
  - in_sof=1 when the counters are already (0,0) is a no-op.
- Simultaneous output transfer and new output production: the new value loads and out_valid stays 1.
- Reset mid-frame:
  - All state returns to reset values immediately.
  - Any pending output is dropped.
  - The next accepted beat is (0,0) whether or not in_sof is set.

Optional Feature:
- Macro POOL_SIGNED_EN.
- Defined: channel values are two's-complement and max compares signed, e.g. DATA_W=8 gives max(0x80, 0x01) = 0x01.
- Undefined: unsigned compare, e.g. max(0x80, 0x01) = 0x80.
- The DATA_W=1 behaviour (OR) applies only when the macro is undefined.

Test Plan:
- Default params, 24x24 frame where channel c pixel(r,x)=1 only at r=2c mod 24, x=2c+1 mod 24 -> 144 outputs; channel c is 1 only at output (c mod 12, c mod 12); out_eof on output 144 only.
- CHANNELS=2, DATA_W=8, IMG_W=IMG_H=4, pixel value = r*4+x on both channels -> outputs 5, 7, 13, 15; out_eof on 15; each output appears 1 cycle after the odd-row odd-col accept.
- out_ready low for 5 cycles while out_valid=1 -> out_data/out_eof held, in_ready=0, no input accepted; on release the stream resumes with no loss or duplication.
- in_sof asserted at (1,3) mid-frame of a 4x4 run, then a full frame -> no output for the aborted window; next 4 outputs match a clean frame.
- rst pulsed asynchronously between clock edges with out_valid=1 -> out_valid, out_data, out_eof go 0 immediately; a following frame without in_sof pools correctly.
- With POOL_SIGNED_EN defined, DATA_W=8, window {0x80, 0xFF, 0x01, 0x7F} -> 0x7F; undefined -> 0xFF.
